// File: rtl/s_axis_frame_parser.sv
// -----------------------------------------------------------------------------
// s_axis_frame_parser
//
// Receives the triggered-acquisition AXI-Stream from the ADC front end. Each
// frame is one TUSER-flagged header beat followed by PAYLOAD_BEATS payload
// beats, the last of which carries TLAST. The parser latches the header time
// stamp, strips the header and forwards payload beats through a one-entry
// registered AXI-Stream master. Framing errors are reported as one-cycle
// pulses plus sticky flags, and frames that complete cleanly are counted.
//
// Ports:
//   AXIS_ACLK         clock
//   AXIS_ARESET       synchronous active-high reset
//   S_AXIS_TDATA      incoming beat
//   S_AXIS_TVALID     incoming beat valid
//   S_AXIS_TUSER      header flag (first beat of a frame)
//   S_AXIS_TLAST      last beat of a frame
//   S_AXIS_TREADY     parser ready (combinational)
//   M_AXIS_TDATA      forwarded payload beat
//   M_AXIS_TVALID     forwarded payload valid
//   M_AXIS_TUSER      first payload beat of a frame
//   M_AXIS_TLAST      last payload beat of a frame
//   M_AXIS_TREADY     downstream ready
//   FRAME_TIME_STAMP  time stamp of the most recent header
//   FRAME_TS_VALID    one-cycle pulse when a header is accepted
//   FRAME_CNT         frames completed without error (wraps)
//   ERR_PULSE         one-cycle pulses: [0] no header, [1] short, [2] long
//   ERR_STICKY        OR-accumulated ERR_PULSE, cleared only by reset
// -----------------------------------------------------------------------------
module s_axis_frame_parser #(
    parameter int TIME_STAMP_WIDTH   = 16,
    parameter int S_AXIS_TDATA_WIDTH = 64,
    parameter int PAYLOAD_BEATS      = 200,
    parameter int FRAME_CNT_WIDTH    = 32
) (
    input  logic                          AXIS_ACLK,
    input  logic                          AXIS_ARESET,
    input  logic [S_AXIS_TDATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic                          S_AXIS_TVALID,
    input  logic                          S_AXIS_TUSER,
    input  logic                          S_AXIS_TLAST,
    output logic                          S_AXIS_TREADY,
    output logic [S_AXIS_TDATA_WIDTH-1:0] M_AXIS_TDATA,
    output logic                          M_AXIS_TVALID,
    output logic                          M_AXIS_TUSER,
    output logic                          M_AXIS_TLAST,
    input  logic                          M_AXIS_TREADY,
    output logic [TIME_STAMP_WIDTH-1:0]   FRAME_TIME_STAMP,
    output logic                          FRAME_TS_VALID,
    output logic [FRAME_CNT_WIDTH-1:0]    FRAME_CNT,
    output logic [2:0]                    ERR_PULSE,
    output logic [2:0]                    ERR_STICKY
);

    // Beat counter wide enough to index PAYLOAD_BEATS-1 (at least one bit).
    localparam int BCNT_WIDTH = (PAYLOAD_BEATS > 1) ? $clog2(PAYLOAD_BEATS) : 1;
    localparam logic [BCNT_WIDTH-1:0] LAST_BEAT = BCNT_WIDTH'(PAYLOAD_BEATS - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PAYLOAD = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;

    // Registered state
    logic [1:0]                    r_state;
    logic [BCNT_WIDTH-1:0]         r_bcnt;
    logic [S_AXIS_TDATA_WIDTH-1:0] r_m_data;
    logic                          r_m_valid;
    logic                          r_m_user;
    logic                          r_m_last;
    logic [TIME_STAMP_WIDTH-1:0]   r_ts;
    logic                          r_ts_valid;
    logic [FRAME_CNT_WIDTH-1:0]    r_frame_cnt;
    logic [2:0]                    r_err_pulse;
    logic [2:0]                    r_err_sticky;

    // Combinational next-state
    logic                          w_ready;
    logic                          w_accept;
    logic [1:0]                    w_state_nxt;
    logic [BCNT_WIDTH-1:0]         w_bcnt_nxt;
    logic [TIME_STAMP_WIDTH-1:0]   w_ts_nxt;
    logic                          w_ts_valid_nxt;
    logic [2:0]                    w_err_nxt;
    logic                          w_cnt_inc;
    logic                          w_fwd;
    logic                          w_fwd_user;
    logic                          w_fwd_last;

    // Ready whenever the output slot is empty or being drained this cycle,
    // identical in every state so dropped beats never stall the source.
    assign w_ready  = !AXIS_ARESET && (!r_m_valid || M_AXIS_TREADY);
    assign w_accept = S_AXIS_TVALID && w_ready;

    always_comb begin
        w_state_nxt    = r_state;
        w_bcnt_nxt     = r_bcnt;
        w_ts_nxt       = r_ts;
        w_ts_valid_nxt = 1'b0;
        w_err_nxt      = '0;
        w_cnt_inc      = 1'b0;
        w_fwd          = 1'b0;
        w_fwd_user     = 1'b0;
        w_fwd_last     = 1'b0;

        if (w_accept) begin
            if (S_AXIS_TUSER) begin
                // Header in any state. Inside PAYLOAD it truncates the
                // running frame; with TLAST it is a frame with no payload.
                w_ts_nxt       = S_AXIS_TDATA[TIME_STAMP_WIDTH-1:0];
                w_ts_valid_nxt = 1'b1;
                w_bcnt_nxt     = '0;
                if ((r_state == ST_PAYLOAD) || S_AXIS_TLAST) begin
                    w_err_nxt[1] = 1'b1;
                end
                w_state_nxt = S_AXIS_TLAST ? ST_IDLE : ST_PAYLOAD;
            end else begin
                case (r_state)
                    ST_PAYLOAD: begin
                        w_fwd      = 1'b1;
                        w_fwd_user = (r_bcnt == '0);
                        if (r_bcnt == LAST_BEAT) begin
                            // Final expected beat always closes the output
                            // frame, whether or not TLAST arrived with it.
                            w_fwd_last = 1'b1;
                            if (S_AXIS_TLAST) begin
                                w_cnt_inc   = 1'b1;
                                w_state_nxt = ST_IDLE;
                            end else begin
                                w_err_nxt[2] = 1'b1;
                                w_state_nxt  = ST_DRAIN;
                            end
                        end else if (S_AXIS_TLAST) begin
                            w_fwd_last   = 1'b1;
                            w_err_nxt[1] = 1'b1;
                            w_state_nxt  = ST_IDLE;
                        end else begin
                            w_bcnt_nxt = r_bcnt + BCNT_WIDTH'(1);
                        end
                    end
                    ST_DRAIN: begin
                        if (S_AXIS_TLAST) begin
                            w_state_nxt = ST_IDLE;
                        end
                    end
                    default: begin
                        // Payload with no preceding header.
                        w_err_nxt[0] = 1'b1;
                        w_state_nxt  = S_AXIS_TLAST ? ST_IDLE : ST_DRAIN;
                    end
                endcase
            end
        end
    end

    // Frame state, pulses and counters
    always_ff @(posedge AXIS_ACLK) begin
        if (AXIS_ARESET) begin
            r_state      <= ST_IDLE;
            r_bcnt       <= '0;
            r_ts         <= '0;
            r_ts_valid   <= 1'b0;
            r_frame_cnt  <= '0;
            r_err_pulse  <= '0;
            r_err_sticky <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_bcnt       <= w_bcnt_nxt;
            r_ts         <= w_ts_nxt;
            r_ts_valid   <= w_ts_valid_nxt;
            r_err_pulse  <= w_err_nxt;
            r_err_sticky <= r_err_sticky | w_err_nxt;
            if (w_cnt_inc) begin
                r_frame_cnt <= r_frame_cnt + FRAME_CNT_WIDTH'(1);
            end
        end
    end

    // One-entry output register. A load can only happen when the slot is
    // empty or draining, so a stalled beat is never overwritten.
    always_ff @(posedge AXIS_ACLK) begin
        if (AXIS_ARESET) begin
            r_m_data  <= '0;
            r_m_valid <= 1'b0;
            r_m_user  <= 1'b0;
            r_m_last  <= 1'b0;
        end else if (w_fwd) begin
            r_m_data  <= S_AXIS_TDATA;
            r_m_valid <= 1'b1;
            r_m_user  <= w_fwd_user;
            r_m_last  <= w_fwd_last;
        end else if (M_AXIS_TREADY) begin
            r_m_valid <= 1'b0;
        end
    end

    assign S_AXIS_TREADY    = w_ready;
    assign M_AXIS_TDATA     = r_m_data;
    assign M_AXIS_TVALID    = r_m_valid;
    assign M_AXIS_TUSER     = r_m_user;
    assign M_AXIS_TLAST     = r_m_last;
    assign FRAME_TIME_STAMP = r_ts;
    assign FRAME_TS_VALID   = r_ts_valid;
    assign FRAME_CNT        = r_frame_cnt;
    assign ERR_PULSE        = r_err_pulse;
    assign ERR_STICKY       = r_err_sticky;

endmodule
